alu_scheduler: RTL and testbench
================================

# alu_scheduler

Two-port scheduler that shares one registered 32-bit ALU between two requesters. Arbitrates round-robin with a per-port request/grant handshake, latches the winner's operands and opcode, sequences the ALU through one execute cycle, and returns the result, zero flag and a one-cycle done pulse to the winning port. Sits between the two datapath clients and the `alu_core` instance it owns. Also maintains per-port completed-operation counters.

## Interface
- `WIDTH`, 32: operand/result width.
- `CNT_W`, 16: width of the per-port completed-operation counters.

- `CLK` input 1: sole clock, rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `REQ0`, `REQ1` input 1: request from port 0 / port 1.
- `OPA0`, `OPB0`, `OPA1`, `OPB1` input WIDTH: operands for each port.
- `SEL0`, `SEL1` input 3: opcode for each port.
- `GNT0`, `GNT1` output 1: one-cycle grant pulse; operands were latched on this edge.
- `DONE0`, `DONE1` output 1: one-cycle result-valid pulse to the owning port.
- `RESULT` output WIDTH: shared result; valid only while `DONE0` or `DONE1` is high.
- `ZFLAG` output 1: 1 when `RESULT` == 0; valid with DONE.
- `BUSY` output 1: high in EXEC and RESP.
- `OPS0`, `OPS1` output CNT_W: completed-operation count per port.

## Operation
- Opcodes:
  - 000: A+B.
  - 001: A&B.
  - 010: A|B.
  - 011: A*B, low WIDTH bits.
  - 100: A−B, mod 2^WIDTH.
  - 101: unsigned A<B, giving 1 or 0.
  - 110 and 111: result 0.
- All arithmetic truncates to WIDTH bits.
- States and transitions:
  - IDLE → EXEC when any REQ is high.
  - EXEC → RESP unconditionally.
  - RESP → IDLE unconditionally.
- IDLE behaviour:
  - On a REQ, assert GNTx for the winner.
  - Latch its OPA, OPB and SEL into the alu_core inputs.
  - Record the owner.
- Arbitration:
  - If only one REQ is high, that port wins.
  - If both are high, the port not granted last wins.
  - The last-granted pointer resets to 1, so port 0 wins the first tie.
- EXEC: alu_core is enabled for one cycle and registers the result.
- RESP:
  - Drive `RESULT` and `ZFLAG`.
  - Pulse DONE for the owner.
  - Increment the owner's OPS counter. Counters wrap from 2^CNT_W−1 to 0.
- REQ is sampled only in IDLE.
- A requester holds REQ, operands and SEL stable until it sees GNT. Operand changes after GNT have no effect on the in-flight operation.
- A REQ dropped before its grant is a withdrawn request; nothing is recorded.
- A REQ still high after RESP is treated as a new request in the next IDLE cycle.
- A SEL of 110 or 111 is a legal operation: it completes with `RESULT`=0, `ZFLAG`=1, and is counted.
- Reset (RST_N low, at any time including mid-operation):
  - State returns to IDLE.
  - All outputs go to 0, except `ZFLAG`=0.
  - Pointer resets to 1; counters reset to 0.
  - Any in-flight operation is discarded, with no DONE.

## Timing
- Cycle n (IDLE, REQ seen): GNT high during n; operands captured at the end of n.
- Cycle n+1: EXEC, `BUSY`=1.
- Cycle n+2: RESP, `BUSY`=1.
  - DONE high, with `RESULT`/`ZFLAG` valid.
  - OPS increments at the end of n+2.
- Cycle n+3: IDLE; the next grant can occur in n+3.
- Latency is grant to DONE = 2 cycles.
- Throughput is one operation per 3 cycles.
- GNT0 and GNT1 are never high together; the same holds for DONE0 and DONE1.
- `RESULT` holds its last value outside DONE; consumers must not rely on it.
- All outputs are registered.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams: `OP_ADD`, `OP_AND`, `OP_OR`, `OP_MUL`, `OP_SUB`, `OP_SLT`;
  - the state encoding for IDLE, EXEC and RESP;
  - default WIDTH.
- Sub-module `alu_core`:
  - registered ALU with ports `CLK`, `RST_N`, `EN`, `A`, `B`, `Sel`, `R`, `Zflag`;
  - one-cycle latency; R updates only when `EN`=1; R resets to 0.
- Arbiter, FSM and counters stay in `alu_scheduler`.

## Test plan
- Single op: REQ0 with A=5, B=7, SEL=000 → GNT0 at cycle 0; DONE0 at cycle 2 with `RESULT`=12, `ZFLAG`=0; `OPS0`=1.
- Tie and fairness: REQ0 and REQ1 held high for 12 cycles → grant order 0,1,0,1, spaced 3 cycles apart; never two GNTs at once.
- Arithmetic edges:
  - 0xFFFFFFFF+1 → 0 with `ZFLAG`=1.
  - 3−5 → 0xFFFFFFFE.
  - 0x10000*0x10000 → 0.
  - SLT 2,3 → 1; SLT 3,2 → 0.
  - SEL=111 → 0 with `ZFLAG`=1.
- Stability: change OPA0 to 99 the cycle after GNT0 → result still uses the latched value.
- Withdrawal: REQ1 pulsed for one cycle while the scheduler is in EXEC → no GNT1 and no DONE1; `OPS1` unchanged.
- Reset mid-op: assert RST_N low during EXEC → all outputs 0 immediately, no DONE afterwards; next tie grants port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: default widths, opcodes and
// the scheduler state encoding.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Registered ALU: computes on A/B/Sel and captures the result and zero flag
// on the clock edge where EN is high; otherwise R holds its value.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Sel,
  output logic [WIDTH-1:0] R,
  output logic             Zflag
);

  logic [WIDTH-1:0] w_res;

  // Combinational opcode decode; reserved opcodes produce zero.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_res unassigned (no latch).
    w_res = '0;
    case (Sel)
      OP_ADD:  w_res = A + B;
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_MUL:  w_res = A * B;
      OP_SUB:  w_res = A - B;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: w_res = '0;
    endcase
  end

  // Result register, updated only when the scheduler enables execution.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      R     <= '0;
      Zflag <= 1'b0;
    end else if (EN) begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      R     <= w_res;
      Zflag <= (w_res == '0);
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one registered ALU between two requesters.
// IDLE grants and latches operands, EXEC clocks the ALU, RESP returns the
// result with a DONE pulse and bumps the owner's completion counter.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] OPA0,
  input  logic [WIDTH-1:0] OPB0,
  input  logic [WIDTH-1:0] OPA1,
  input  logic [WIDTH-1:0] OPB1,
  input  logic [2:0]       SEL0,
  input  logic [2:0]       SEL1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZFLAG,
  output logic             BUSY,
  output logic [CNT_W-1:0] OPS0,
  output logic [CNT_W-1:0] OPS1
);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last;      // port granted most recently
  logic             r_owner;     // port owning the in-flight operation
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [2:0]       r_sel;
  logic             w_grant;
  logic             w_winner;
  logic             w_respond;
  logic             w_alu_en;
  logic [WIDTH-1:0] w_alu_r;
  logic             w_alu_z;

  // Next-state, arbitration and response decode.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_winner     = 1'b0;
    w_respond    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          w_grant      = 1'b1;
          w_next_state = S_EXEC;
          // On a tie the port that did not win last time goes first.
          w_winner     = (REQ0 && REQ1) ? ~r_last : REQ1;
        end
      end
      S_EXEC:  w_next_state = S_RESP;
      S_RESP: begin
        w_respond    = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_alu_en = (r_state == S_EXEC);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Grant pulse plus operand/owner capture on the granting edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sel   <= '0;
    end else begin
      GNT0 <= w_grant & ~w_winner;
      GNT1 <= w_grant &  w_winner;
      if (w_grant) begin
        r_last  <= w_winner;
        r_owner <= w_winner;
        r_opa   <= w_winner ? OPA1 : OPA0;
        r_opb   <= w_winner ? OPB1 : OPB0;
        r_sel   <= w_winner ? SEL1 : SEL0;
      end
    end
  end

  // Result return: DONE pulse to the owner, result/flag held between ops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DONE0  <= 1'b0;
      DONE1  <= 1'b0;
      RESULT <= '0;
      ZFLAG  <= 1'b0;
    end else begin
      DONE0 <= w_respond & ~r_owner;
      DONE1 <= w_respond &  r_owner;
      if (w_respond) begin
        RESULT <= w_alu_r;
        ZFLAG  <= w_alu_z;
      end
    end
  end

  // Busy covers the EXEC and RESP cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) BUSY <= 1'b0;
    else        BUSY <= (w_next_state != S_IDLE);
  end

  // Per-port completed-operation counters, wrapping naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OPS0 <= '0;
      OPS1 <= '0;
    end else if (w_respond) begin
      if (r_owner) OPS1 <= OPS1 + CNT_W'(1);
      else         OPS0 <= OPS0 + CNT_W'(1);
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (w_alu_en),
    .A     (r_opa),
    .B     (r_opb),
    .Sel   (r_sel),
    .R     (w_alu_r),
    .Zflag (w_alu_z)
  );

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: reset values, tie fairness, a vector
// table of single operations, request withdrawal and reset mid-operation.
module tb_alu_scheduler;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ0, REQ1;
  logic [31:0] OPA0, OPB0, OPA1, OPB1;
  logic [2:0]  SEL0, SEL1;
  logic        GNT0, GNT1, DONE0, DONE1, ZFLAG, BUSY;
  logic [31:0] RESULT;
  logic [15:0] OPS0, OPS1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] m_ops0 = '0;
  logic [15:0] m_ops1 = '0;

  typedef struct {
    bit          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [31:0] exp_r;
    bit          exp_z;
  } vec_t;

  vec_t vecs[13];

  always #5 CLK = ~CLK;

  alu_scheduler #(.WIDTH(32), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .REQ1(REQ1),
    .OPA0(OPA0), .OPB0(OPB0), .OPA1(OPA1), .OPB1(OPB1),
    .SEL0(SEL0), .SEL1(SEL1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .RESULT(RESULT), .ZFLAG(ZFLAG), .BUSY(BUSY),
    .OPS0(OPS0), .OPS1(OPS1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    {30'd0, GNT1, GNT0}, 32'd0);
    check({tag, "_done"},   {30'd0, DONE1, DONE0}, 32'd0);
    check({tag, "_result"}, RESULT, 32'd0);
    check({tag, "_zflag"},  {31'd0, ZFLAG}, 32'd0);
    check({tag, "_busy"},   {31'd0, BUSY}, 32'd0);
    check({tag, "_ops0"},   {16'd0, OPS0}, 32'd0);
    check({tag, "_ops1"},   {16'd0, OPS1}, 32'd0);
  endtask

  // One isolated operation, starting in an IDLE cycle. Operands are
  // scrambled right after the grant to prove they were latched.
  task automatic run_op(input string tag, input vec_t v);
    if (v.port) begin REQ1 = 1'b1; OPA1 = v.a; OPB1 = v.b; SEL1 = v.sel; end
    else        begin REQ0 = 1'b1; OPA0 = v.a; OPB0 = v.b; SEL0 = v.sel; end
    tick();
    check({tag, "_gnt"}, {30'd0, GNT1, GNT0}, v.port ? 32'd2 : 32'd1);
    check({tag, "_busy_exec"}, {31'd0, BUSY}, 32'd1);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    if (v.port) begin OPA1 = 32'd99; OPB1 = v.b ^ 32'h5A5A_5A5A; SEL1 = v.sel ^ 3'b001; end
    else        begin OPA0 = 32'd99; OPB0 = v.b ^ 32'h5A5A_5A5A; SEL0 = v.sel ^ 3'b001; end
    tick();
    check({tag, "_done_early"}, {30'd0, DONE1, DONE0}, 32'd0);
    check({tag, "_busy_resp"}, {31'd0, BUSY}, 32'd1);
    tick();
    if (v.port) m_ops1++; else m_ops0++;
    check({tag, "_done"},   {30'd0, DONE1, DONE0}, v.port ? 32'd2 : 32'd1);
    check({tag, "_result"}, RESULT, v.exp_r);
    check({tag, "_zflag"},  {31'd0, ZFLAG}, {31'd0, v.exp_z});
    check({tag, "_ops0"},   {16'd0, OPS0}, {16'd0, m_ops0});
    check({tag, "_ops1"},   {16'd0, OPS1}, {16'd0, m_ops1});
    check({tag, "_busy_idle"}, {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'd5,          32'd7,          3'b000, 32'd12,         1'b0};
    vecs[1]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          3'b000, 32'd0,          1'b1};
    vecs[2]  = '{1'b1, 32'd3,          32'd5,          3'b100, 32'hFFFF_FFFE,  1'b0};
    vecs[3]  = '{1'b0, 32'h0001_0000,  32'h0001_0000,  3'b011, 32'd0,          1'b1};
    vecs[4]  = '{1'b1, 32'd2,          32'd3,          3'b101, 32'd1,          1'b0};
    vecs[5]  = '{1'b0, 32'd3,          32'd2,          3'b101, 32'd0,          1'b1};
    vecs[6]  = '{1'b1, 32'd5,          32'd6,          3'b111, 32'd0,          1'b1};
    vecs[7]  = '{1'b0, 32'h0000_F0F0,  32'h0000_0FF0,  3'b001, 32'h0000_00F0,  1'b0};
    vecs[8]  = '{1'b1, 32'h0000_F000,  32'h0000_000F,  3'b010, 32'h0000_F00F,  1'b0};
    vecs[9]  = '{1'b0, 32'd1234,       32'd5678,       3'b110, 32'd0,          1'b1};
    vecs[10] = '{1'b1, 32'd6,          32'd7,          3'b011, 32'd42,         1'b0};
    vecs[11] = '{1'b0, 32'd100,        32'd100,        3'b100, 32'd0,          1'b1};
    vecs[12] = '{1'b1, 32'h1234_5678,  32'h0000_0010,  3'b000, 32'h1234_5688,  1'b0};

    RST_N = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0;
    OPA0 = '0; OPB0 = '0; OPA1 = '0; OPB1 = '0;
    SEL0 = '0; SEL1 = '0;

    // Reset values, during and just after reset.
    #3;
    check_all_zero("rst_in");
    #9;
    RST_N = 1'b1;
    tick();
    check_all_zero("rst_out");

    // Tie held for 12 cycles: grants alternate 0,1,0,1 three cycles apart.
    OPA0 = 32'd1;  OPB0 = 32'd2; SEL0 = 3'b000;
    OPA1 = 32'd10; OPB1 = 32'd4; SEL1 = 3'b100;
    REQ0 = 1'b1; REQ1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("tie_c%0d_gnt", k), {30'd0, GNT1, GNT0},
            (k == 1 || k == 7) ? 32'd1 : (k == 4 || k == 10) ? 32'd2 : 32'd0);
      check($sformatf("tie_c%0d_done", k), {30'd0, DONE1, DONE0},
            (k == 3 || k == 9) ? 32'd1 : (k == 6 || k == 12) ? 32'd2 : 32'd0);
      if (k == 3 || k == 9)  check($sformatf("tie_c%0d_result", k), RESULT, 32'd3);
      if (k == 6 || k == 12) check($sformatf("tie_c%0d_result", k), RESULT, 32'd6);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    m_ops0 = m_ops0 + 16'd2;
    m_ops1 = m_ops1 + 16'd2;
    check("tie_ops0", {16'd0, OPS0}, {16'd0, m_ops0});
    check("tie_ops1", {16'd0, OPS1}, {16'd0, m_ops1});

    // Vector table of isolated operations.
    for (int i = 0; i < 13; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // REQ1 pulsed only during EXEC of a port-0 operation is never seen.
    REQ0 = 1'b1; OPA0 = 32'd1; OPB0 = 32'd1; SEL0 = 3'b000;
    tick();
    check("wd_gnt0", {30'd0, GNT1, GNT0}, 32'd1);
    REQ0 = 1'b0;
    REQ1 = 1'b1; OPA1 = 32'd50; OPB1 = 32'd50; SEL1 = 3'b000;
    tick();
    REQ1 = 1'b0;
    check("wd_resp_gnt", {30'd0, GNT1, GNT0}, 32'd0);
    tick();
    m_ops0++;
    check("wd_done", {30'd0, DONE1, DONE0}, 32'd1);
    check("wd_result", RESULT, 32'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("wd_after%0d_gnt", k),  {30'd0, GNT1, GNT0}, 32'd0);
      check($sformatf("wd_after%0d_done", k), {30'd0, DONE1, DONE0}, 32'd0);
      check($sformatf("wd_after%0d_busy", k), {31'd0, BUSY}, 32'd0);
    end
    check("wd_ops0", {16'd0, OPS0}, {16'd0, m_ops0});
    check("wd_ops1", {16'd0, OPS1}, {16'd0, m_ops1});

    // Reset asserted during EXEC discards the operation.
    REQ0 = 1'b1; OPA0 = 32'd7; OPB0 = 32'd8; SEL0 = 3'b000;
    tick();
    check("rm_gnt0", {30'd0, GNT1, GNT0}, 32'd1);
    REQ0 = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    m_ops0 = '0;
    m_ops1 = '0;
    check_all_zero("rm_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rm_after%0d_done", k), {30'd0, DONE1, DONE0}, 32'd0);
      check($sformatf("rm_after%0d_busy", k), {31'd0, BUSY}, 32'd0);
    end
    check("rm_ops0", {16'd0, OPS0}, 32'd0);

    // First tie after reset goes to port 0 again.
    OPA1 = 32'd40; OPB1 = 32'd2; SEL1 = 3'b000;
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    check("rm_tie_gnt", {30'd0, GNT1, GNT0}, 32'd1);
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
    tick();
    check("rm_tie_done", {30'd0, DONE1, DONE0}, 32'd1);
    check("rm_tie_result", RESULT, 32'd15);
    check("rm_tie_ops0", {16'd0, OPS0}, 32'd1);
    check("rm_tie_ops1", {16'd0, OPS1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
